uart_core: RTL and testbench
============================

# uart_core

Full-duplex 8N1 UART: one byte-wide transmitter and one byte-wide receiver sharing a single system clock. Default timing is 115200 baud from a 100 MHz clock. It sits between a byte-oriented host interface (`tx_data`/`tx_send`/`rx_data`/`rx_valid`) and the two serial pins. Module name: `uart_core`.

## Interface
- `CLKS_PER_BIT`, default 868: clock cycles per serial bit (100 MHz / 115200, truncated). Must be at least 4.
- `clock`, input, 1: system clock; all logic is on the rising edge.
- `rst`, input, 1: reset, synchronous and active-high.
- `tx_data`, input, 8: byte to transmit; captured when a send is accepted.
- `tx_send`, input, 1: send request; acted on only while `tx_busy`=0.
- `tx_busy`, output, 1: transmitter is sending a frame.
- `tx`, output, 1: serial out; idles high.
- `rx`, input, 1: asynchronous serial in; idles high.
- `rx_data`, output, 8: last correctly received byte; held until the next good frame.
- `rx_valid`, output, 1: one-cycle pulse when `rx_data` is updated.

## Operation
- Frame format: start bit 0, then 8 data bits LSB first, then stop bit 1. No parity.
- Reset values:
  - `tx`=1, `tx_busy`=0, `rx_valid`=0, `rx_data`=0x00.
  - Synchronizer flops = 1; both FSMs in IDLE; counters and bit indices = 0.
- TX FSM states: IDLE, START, DATA, STOP.
  - IDLE: if `tx_send`=1, latch `tx_data` into a shift register and go to START.
  - START: `tx`=0 for `CLKS_PER_BIT` cycles.
  - DATA: drive bit[i] for `CLKS_PER_BIT` cycles each, i=0..7.
  - STOP: `tx`=1 for `CLKS_PER_BIT` cycles, then go to IDLE.
  - `tx_busy`=1 in every state except IDLE.
  - `tx_send` while busy is ignored; it is not queued.
  - Changing `tx_data` after acceptance does not affect the frame in flight.
- RX path:
  - `rx` passes through a 2-flop synchronizer; the FSM uses only the synchronized value `rx_s`.
  - RX FSM states: IDLE, START, DATA, STOP, WAIT_IDLE.
- RX transitions (one counter, cleared on every state entry):
  - IDLE: `rx_s`=0 goes to START.
  - START: at count `CLKS_PER_BIT/2-1`, if `rx_s`=0 go to DATA; otherwise treat it as a glitch and return to IDLE.
  - DATA: at count `CLKS_PER_BIT-1`, shift `rx_s` in as the next bit (LSB first). After the 8th bit, go to STOP.
  - STOP: at count `CLKS_PER_BIT-1`:
    - if `rx_s`=1, load `rx_data`, pulse `rx_valid`, go to IDLE;
    - if `rx_s`=0 (framing error), there is no pulse, `rx_data` is unchanged, go to WAIT_IDLE.
  - WAIT_IDLE: stays until `rx_s`=1, then goes to IDLE.
- Result: samples fall at mid-bit. RX returns to IDLE mid-stop-bit, so back-to-back frames with no idle gap are received.
- TX and RX are fully independent; simultaneous operation is required.
- `rst` asserted mid-frame aborts both FSMs immediately to reset values. Any partial byte is discarded.

## Timing
- `tx_send` is sampled high in IDLE at edge N:
  - at N+1, `tx`=0 and `tx_busy`=1;
  - each bit lasts exactly `CLKS_PER_BIT` cycles;
  - `tx_busy` falls at N+1+10·`CLKS_PER_BIT` (8681 cycles at default), with `tx`=1.
- A new `tx_send` is accepted in the first cycle `tx_busy`=0. Back-to-back frames have no idle gap.
- RX: let E be the first clock edge at which raw `rx`=0 is registered.
  - `rx_s` goes low 1 cycle later; START is entered 1 cycle after that.
  - `rx_valid` pulses about 2 + `CLKS_PER_BIT/2` + 9·`CLKS_PER_BIT` cycles after E (≈8248 at default), in the middle of the stop bit.
- `rx_valid` is high for exactly 1 cycle per good frame. `rx_data` is valid in that same cycle and is held afterwards.
- All outputs are registered; no combinational input-to-output paths.

## Test plan
- Reset: hold `rst` for 1 cycle -> `tx`=1, `tx_busy`=0, `rx_valid`=0, `rx_data`=0x00.
- RX back-to-back: drive 0xA5 then 0x3C on `rx`, 868 cycles per bit, no gap -> exactly two `rx_valid` pulses carrying 0xA5 then 0x3C; `rx_data` holds 0x3C afterwards.
- TX waveform: pulse `tx_send` with `tx_data`=0x5A -> `tx` sequence 0,0,1,0,1,1,0,1,0,1 with each bit 868 cycles; `tx_busy` high for 8680 cycles; a second `tx_send`=0xFF mid-frame is ignored.
- Loopback: tie `tx` to `rx` and send 0x00, 0xFF, 0x81 -> `rx_valid` pulses with identical bytes in order.
- Glitch: `rx` low for 300 cycles then high -> no `rx_valid`; a following valid 0x55 frame is received correctly.
- Framing error: send 0xC3 with stop bit 0, then release `rx` high -> no `rx_valid`, `rx_data` unchanged; the next good frame 0x12 is received.

Source files
------------

// File: rtl/uart_core.sv
// uart_core: full-duplex 8N1 UART (start 0, 8 data bits LSB first, stop 1).
// TX and RX are independent FSMs sharing one clock. Every host-facing and
// serial output is a flop, so there is no combinational path from inputs.
// tx_state_dbg / rx_state_dbg expose the current FSM states for observation.
module uart_core #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clock,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_send,
  output logic       tx_busy,
  output logic       tx,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic [1:0] tx_state_dbg,
  output logic [2:0] rx_state_dbg
);

  // Host handshake: tx_send is a request that is taken only in a cycle where
  // tx_busy=0 (tx_data captured in that cycle); requests while busy are dropped.
  // rx_valid is a one-cycle pulse with no back-pressure; rx_data is valid in
  // that cycle and held until the next good frame.

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_IDLE} rx_state_t;

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  // ---------------------------------------------------------------- TX
  tx_state_t     tx_state, tx_state_n;
  logic [CW-1:0] tx_cnt, tx_cnt_n;
  logic [2:0]    tx_idx, tx_idx_n;
  logic [7:0]    tx_buf, tx_buf_n;
  logic          tx_q, tx_n;
  logic          tx_busy_q, tx_busy_n;

  // TX state register and registered outputs
  always_ff @(posedge clock) begin
    if (rst) begin
      tx_state  <= TX_IDLE;
      tx_cnt    <= '0;
      tx_idx    <= '0;
      tx_buf    <= '0;
      tx_q      <= 1'b1;
      tx_busy_q <= 1'b0;
    end else begin
      tx_state  <= tx_state_n;
      tx_cnt    <= tx_cnt_n;
      tx_idx    <= tx_idx_n;
      tx_buf    <= tx_buf_n;
      tx_q      <= tx_n;
      tx_busy_q <= tx_busy_n;
    end
  end

  // TX next state: each non-idle state lasts CLKS_PER_BIT cycles
  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n   = tx_cnt + CW'(1);
    tx_idx_n   = tx_idx;
    tx_buf_n   = tx_buf;
    case (tx_state)
      TX_IDLE: begin
        tx_cnt_n = '0;
        if (tx_send) begin
          tx_buf_n   = tx_data;
          tx_idx_n   = '0;
          tx_state_n = TX_START;
        end
      end
      TX_START: begin
        if (tx_cnt == BIT_LAST) begin
          tx_cnt_n   = '0;
          tx_idx_n   = '0;
          tx_state_n = TX_DATA;
        end
      end
      TX_DATA: begin
        if (tx_cnt == BIT_LAST) begin
          tx_cnt_n = '0;
          if (tx_idx == 3'd7) tx_state_n = TX_STOP;
          else                tx_idx_n   = tx_idx + 3'd1;
        end
      end
      TX_STOP: begin
        if (tx_cnt == BIT_LAST) begin
          tx_cnt_n   = '0;
          tx_idx_n   = '0;
          tx_state_n = TX_IDLE;
        end
      end
      default: begin
        tx_cnt_n   = '0;
        tx_state_n = TX_IDLE;
      end
    endcase
  end

  // TX outputs decoded from the next state so the pin flop lines up with it
  always_comb begin
    tx_busy_n = (tx_state_n != TX_IDLE);
    tx_n      = 1'b1;
    case (tx_state_n)
      TX_START: tx_n = 1'b0;
      TX_DATA:  tx_n = tx_buf_n[tx_idx_n];
      default:  tx_n = 1'b1;
    endcase
  end

  assign tx           = tx_q;
  assign tx_busy      = tx_busy_q;
  assign tx_state_dbg = tx_state;

  // ---------------------------------------------------------------- RX
  rx_state_t     rx_state, rx_state_n;
  logic [CW-1:0] rx_cnt, rx_cnt_n;
  logic [2:0]    rx_idx, rx_idx_n;
  logic [7:0]    rx_shift, rx_shift_n;
  logic [7:0]    rx_data_q, rx_data_n;
  logic          rx_valid_q, rx_valid_n;
  logic          rx_meta, rx_s;

  // Two-flop synchronizer for the asynchronous rx pin; idles high
  always_ff @(posedge clock) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // RX state register and registered outputs
  always_ff @(posedge clock) begin
    if (rst) begin
      rx_state   <= RX_IDLE;
      rx_cnt     <= '0;
      rx_idx     <= '0;
      rx_shift   <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      rx_state   <= rx_state_n;
      rx_cnt     <= rx_cnt_n;
      rx_idx     <= rx_idx_n;
      rx_shift   <= rx_shift_n;
      rx_data_q  <= rx_data_n;
      rx_valid_q <= rx_valid_n;
    end
  end

  // RX next state: recheck start at half a bit, then sample every full bit
  always_comb begin
    rx_state_n = rx_state;
    rx_cnt_n   = rx_cnt + CW'(1);
    rx_idx_n   = rx_idx;
    rx_shift_n = rx_shift;
    case (rx_state)
      RX_IDLE: begin
        rx_cnt_n = '0;
        rx_idx_n = '0;
        if (!rx_s) rx_state_n = RX_START;
      end
      RX_START: begin
        if (rx_cnt == HALF_LAST) begin
          rx_cnt_n   = '0;
          rx_idx_n   = '0;
          rx_state_n = rx_s ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_cnt == BIT_LAST) begin
          rx_cnt_n   = '0;
          rx_shift_n = {rx_s, rx_shift[7:1]};
          if (rx_idx == 3'd7) rx_state_n = RX_STOP;
          else                rx_idx_n   = rx_idx + 3'd1;
        end
      end
      RX_STOP: begin
        if (rx_cnt == BIT_LAST) begin
          rx_cnt_n   = '0;
          rx_state_n = rx_s ? RX_IDLE : RX_WAIT_IDLE;
        end
      end
      RX_WAIT_IDLE: begin
        rx_cnt_n = '0;
        if (rx_s) rx_state_n = RX_IDLE;
      end
      default: begin
        rx_cnt_n   = '0;
        rx_state_n = RX_IDLE;
      end
    endcase
  end

  // RX outputs: publish the byte only when the stop bit samples high
  always_comb begin
    rx_valid_n = (rx_state == RX_STOP) && (rx_cnt == BIT_LAST) && rx_s;
    rx_data_n  = rx_valid_n ? rx_shift : rx_data_q;
  end

  assign rx_data      = rx_data_q;
  assign rx_valid     = rx_valid_q;
  assign rx_state_dbg = rx_state;

endmodule

// File: tb/tb_uart_core.sv
// tb_uart_core: directed scenarios for uart_core with a receive scoreboard.
// A shortened bit time keeps the run small; all timing scales with CPB.
module tb_uart_core;

  localparam int CPB = 100;

  logic       clock = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_send = 1'b0;
  logic       tx_busy;
  logic       tx;
  logic       rx_drv = 1'b1;
  logic       loop_en = 1'b0;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [1:0] tx_state_dbg;
  logic [2:0] rx_state_dbg;

  int total = 0;
  int bad = 0;
  int pulses = 0;
  logic [7:0] exp_q[$];
  logic [7:0] mon_exp;

  assign rx = loop_en ? tx : rx_drv;

  uart_core #(.CLKS_PER_BIT(CPB)) dut (
    .clock        (clock),
    .rst          (rst),
    .tx_data      (tx_data),
    .tx_send      (tx_send),
    .tx_busy      (tx_busy),
    .tx           (tx),
    .rx           (rx),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .tx_state_dbg (tx_state_dbg),
    .rx_state_dbg (rx_state_dbg)
  );

  // clock
  always #5 clock = ~clock;

  // scoreboard: every rx_valid cycle must match the head of exp_q
  always @(negedge clock) begin
    if (rx_valid === 1'b1) begin
      pulses++;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL rx_unexpected: rx_valid pulse with rx_data=%02h, expected no pulse", rx_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if (rx_data !== mon_exp) begin
          bad++;
          $display("FAIL rx_byte: got %02h, expected %02h", rx_data, mon_exp);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // drive one serial frame on rx, LSB first, with a chosen stop bit
  task automatic send_rx(input logic [7:0] d, input logic stop_bit);
    logic [9:0] f;
    f = {stop_bit, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx_drv = f[i];
      repeat (CPB) tick();
    end
    rx_drv = 1'b1;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s_drain: %0d bytes still expected after %0d cycles, required 0", name, exp_q.size(), budget);
      exp_q.delete();
    end
  endtask

  task automatic check_bit(input string name, input logic got, input logic want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %b, expected %b", name, got, want);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    check_bit("reset_tx", tx, 1'b1);
    check_bit("reset_tx_busy", tx_busy, 1'b0);
    check_bit("reset_rx_valid", rx_valid, 1'b0);
    total++;
    if (rx_data !== 8'h00) begin
      bad++;
      $display("FAIL reset_rx_data: got %02h, expected 00", rx_data);
    end
    rst = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_rx_back_to_back();
    int p0;
    p0 = pulses;
    exp_q.push_back(8'hA5);
    send_rx(8'hA5, 1'b1);
    exp_q.push_back(8'h3C);
    send_rx(8'h3C, 1'b1);
    wait_drain("rx_b2b", 4 * CPB);
    repeat (CPB) tick();
    total++;
    if (pulses - p0 != 2) begin
      bad++;
      $display("FAIL rx_b2b_pulses: got %0d pulses, expected 2", pulses - p0);
    end
    total++;
    if (rx_data !== 8'h3C) begin
      bad++;
      $display("FAIL rx_b2b_hold: got %02h, expected 3c", rx_data);
    end
  endtask

  task automatic test_tx_waveform();
    logic [9:0] f;
    int bit_err;
    int busy_cnt;
    int idle_err;
    f = {1'b1, 8'h5A, 1'b0};
    tx_data = 8'h5A;
    tx_send = 1'b1;
    tick();
    tx_send = 1'b0;
    tx_data = 8'h00;
    busy_cnt = 0;
    bit_err = 0;
    for (int k = 0; k < 10 * CPB; k++) begin
      if (tx !== f[k / CPB]) bit_err++;
      if (tx_busy === 1'b1) busy_cnt++;
      if (k % CPB == CPB - 1) begin
        total++;
        if (bit_err != 0) begin
          bad++;
          $display("FAIL tx_bit%0d: %0d cycles differed, expected level %b", k / CPB, bit_err, f[k / CPB]);
        end
        bit_err = 0;
      end
      if (k == 3 * CPB) begin
        tx_data = 8'hFF;
        tx_send = 1'b1;
      end
      if (k == 3 * CPB + 1) tx_send = 1'b0;
      tick();
    end
    total++;
    if (busy_cnt != 10 * CPB) begin
      bad++;
      $display("FAIL tx_busy_len: got %0d cycles, expected %0d", busy_cnt, 10 * CPB);
    end
    check_bit("tx_end_busy", tx_busy, 1'b0);
    check_bit("tx_end_line", tx, 1'b1);
    idle_err = 0;
    repeat (2 * CPB) begin
      if (tx !== 1'b1 || tx_busy !== 1'b0) idle_err++;
      tick();
    end
    total++;
    if (idle_err != 0) begin
      bad++;
      $display("FAIL tx_ignored_send: %0d non-idle cycles after frame, expected 0", idle_err);
    end
  endtask

  task automatic test_loopback();
    logic [7:0] bytes [3];
    int n;
    bytes[0] = 8'h00;
    bytes[1] = 8'hFF;
    bytes[2] = 8'h81;
    loop_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n = 0;
      while (tx_busy !== 1'b0 && n < 12 * CPB) begin
        tick();
        n++;
      end
      total++;
      if (tx_busy !== 1'b0) begin
        bad++;
        $display("FAIL loop_tx_idle: tx_busy=%b after %0d cycles, expected 0", tx_busy, n);
      end
      exp_q.push_back(bytes[i]);
      tx_data = bytes[i];
      tx_send = 1'b1;
      tick();
      tx_send = 1'b0;
    end
    wait_drain("loopback", 12 * CPB);
    n = 0;
    while (tx_busy !== 1'b0 && n < 2 * CPB) begin
      tick();
      n++;
    end
    loop_en = 1'b0;
    repeat (CPB) tick();
  endtask

  task automatic test_glitch();
    int p0;
    p0 = pulses;
    rx_drv = 1'b0;
    repeat (CPB * 3 / 10) tick();
    rx_drv = 1'b1;
    repeat (2 * CPB) tick();
    total++;
    if (pulses != p0) begin
      bad++;
      $display("FAIL glitch_pulse: got %0d pulses, expected 0", pulses - p0);
    end
    exp_q.push_back(8'h55);
    send_rx(8'h55, 1'b1);
    wait_drain("glitch", 4 * CPB);
    repeat (CPB) tick();
  endtask

  task automatic test_framing();
    int p0;
    p0 = pulses;
    send_rx(8'hC3, 1'b0);
    repeat (2 * CPB) tick();
    total++;
    if (pulses != p0) begin
      bad++;
      $display("FAIL framing_pulse: got %0d pulses, expected 0", pulses - p0);
    end
    total++;
    if (rx_data !== 8'h55) begin
      bad++;
      $display("FAIL framing_hold: got %02h, expected 55", rx_data);
    end
    exp_q.push_back(8'h12);
    send_rx(8'h12, 1'b1);
    wait_drain("framing", 4 * CPB);
    repeat (CPB) tick();
  endtask

  task automatic test_reset_mid_frame();
    int p0;
    tx_data = 8'h99;
    tx_send = 1'b1;
    tick();
    tx_send = 1'b0;
    rx_drv = 1'b0;
    repeat (3 * CPB) tick();
    rst = 1'b1;
    rx_drv = 1'b1;
    tick();
    check_bit("midrst_tx", tx, 1'b1);
    check_bit("midrst_tx_busy", tx_busy, 1'b0);
    check_bit("midrst_rx_valid", rx_valid, 1'b0);
    total++;
    if (rx_data !== 8'h00) begin
      bad++;
      $display("FAIL midrst_rx_data: got %02h, expected 00", rx_data);
    end
    rst = 1'b0;
    p0 = pulses;
    repeat (12 * CPB) tick();
    total++;
    if (pulses != p0 || tx_busy !== 1'b0) begin
      bad++;
      $display("FAIL midrst_quiet: got %0d pulses busy=%b, expected 0 pulses busy=0", pulses - p0, tx_busy);
    end
  endtask

  initial begin
    test_reset();
    test_rx_back_to_back();
    test_tx_waveform();
    test_loopback();
    test_glitch();
    test_framing();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
